fifo_rate_ctrl: RTL and testbench
=================================

// Module: fifo_rate_ctrl
// PURPOSE
//   Parametrised rate-controlled FIFO exerciser for board bring-up. Holds a single-clock FIFO of
//   DATA_W x DEPTH and runs start/stop-gated write and read tick timers with selectable traffic
//   modes: continuous, fill-then-drain-N, fill-then-drain-all. Provides sticky error flags and
//   stretched activity pulses for LEDs. Sits between debounced board buttons/switches and PMOD/LED pins.
// PARAMETERS
//   DATA_W     8            data width
//   DEPTH      16           FIFO entries; power of 2, >=4
//   WR_PERIOD  100_000_000  clk cycles between write ticks (>=2)
//   RD_PERIOD  200_000_000  clk cycles between read ticks (>=2)
//   DRAIN_N    3            reads per drain phase in mode 1 (1..DEPTH)
//   AF_MARGIN  2            almost_full when level >= DEPTH-AF_MARGIN
//   AE_MARGIN  2            almost_empty when level <= AE_MARGIN
//   STRETCH    2**24-1      LED stretch length in cycles
// PORTS
//   clk          in   1              single system clock
//   rst          in   1              asynchronous, active-high reset
//   start_stop   in   1              debounced level; each rising edge toggles run
//   mode         in   2              0 continuous, 1 fill/drain-N, 2 fill/drain-all, 3 = continuous
//   clr_err      in   1              synchronous clear of overflow/underflow
//   din          in   DATA_W         write data, sampled in the write-strobe cycle
//   dout         out  DATA_W         last read word, registered
//   wr_strobe    out  1              1-cycle pulse per accepted write
//   rd_strobe    out  1              1-cycle pulse per accepted read
//   wr_act       out  1              stretched wr_strobe
//   rd_act       out  1              stretched rd_strobe
//   full, empty, almost_full, almost_empty  out  1 each  occupancy flags
//   overflow     out  1              sticky: write tick while full
//   underflow    out  1              sticky: read tick while empty
//   level        out  $clog2(DEPTH)+1  occupancy 0..DEPTH
//   run          out  1              current run state
// BEHAVIOUR
//   - Reset values: run=0, state IDLE, level=0, dout=0, all strobes/act/error flags 0.
//     empty=1 and almost_empty=1; full and almost_full follow level combinationally.
//   - run toggles on the cycle after the start_stop rising edge. The edge detect uses a registered copy of start_stop.
//   - Tick timers: count 0..PERIOD-1 only while run=1. Each timer pulses when count==PERIOD-1, then wraps.
//     Timers are held at 0 while run=0, so the first tick comes PERIOD cycles after run rises.
//   - FSM states: IDLE, CONT, FILL, DRAIN.
//     - mode is sampled only on the IDLE exit.
//     - IDLE exit (run=1): mode 0/3 -> CONT; mode 1/2 -> FILL.
//     - run=0 from any state -> IDLE next cycle. FIFO contents and error flags are retained.
//     - CONT: write on wr_tick&!full; read on rd_tick&!empty. Both may occur in the same cycle; level is unchanged.
//     - FILL: writes only. On the cycle level becomes DEPTH -> DRAIN, drain_cnt=0.
//     - DRAIN: reads only; drain_cnt+1 per read.
//       - Mode 1: -> FILL after the DRAIN_N-th read, or when the FIFO empties, whichever comes first.
//       - Mode 2: -> FILL on the read that empties the FIFO.
//   - Enables are gated on pre-cycle flags: a full FIFO rejects a write even when a read occurs in the same cycle.
//   - overflow sets on wr_tick in CONT/FILL with full=1. underflow sets on rd_tick in CONT/DRAIN with empty=1.
//     clr_err clears both; a set event in the same cycle wins.
//   - Strobe timing: wr_strobe/rd_strobe are combinational from the registered state and the tick.
//     Memory write happens on the same edge. dout updates one cycle after rd_strobe.
//   - Pointers are $clog2(DEPTH) bits wide and wrap naturally. level is a separate up/down counter.
//   - Stretch counters reload to STRETCH on each strobe (retriggerable); act = (cnt!=0).
// STRUCTURE
//   - fifo_ctrl_pkg: state enum {IDLE,CONT,FILL,DRAIN}; mode constants MODE_CONT/MODE_DRAIN_N/MODE_DRAIN_ALL.
//   - Sub-module fifo_tick_gen (PERIOD parameter; en, tick), instanced twice.
//   - Storage, FSM and stretch logic are inline.
// TESTING (DATA_W=8, DEPTH=8, WR_PERIOD=4, RD_PERIOD=8, DRAIN_N=3, STRETCH=5 unless noted)
//   1. Reset mid-traffic -> empty=1, almost_empty=1, level=0, dout=0, run=0, flags 0 within the reset assertion.
//   2. mode=1, start, din=cycle index -> 8 writes at 4-cycle spacing, full=1, DRAIN, 3 reads (level 5), back to FILL.
//   3. mode=2, din=0x10..0x17 -> after full, 8 reads at 8-cycle spacing; dout=0x10..0x17 in order; empty -> FILL.
//   4. mode=0 -> level climbs to 8; next wr_tick with full sets overflow; clr_err pulse -> overflow=0.
//   5. RD_PERIOD=2, mode=0 -> first rd_tick (cycle 2) with empty sets underflow; no rd_strobe.
//   6. Stop in DRAIN at level 6 -> IDLE, no strobes, level held at 6. Restart with mode=0 -> CONT; wr_act stays high 5 cycles per write.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared types and constants for the rate-controlled FIFO exerciser.
package fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONT  = 2'd1,
        FILL  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam logic [1:0] MODE_CONT      = 2'd0;
    localparam logic [1:0] MODE_DRAIN_N   = 2'd1;
    localparam logic [1:0] MODE_DRAIN_ALL = 2'd2;

    // Modes 1 and 2 start with a fill phase; 0 and 3 run continuous traffic.
    function automatic logic is_fill_mode(input logic [1:0] m);
        return (m == MODE_DRAIN_N) || (m == MODE_DRAIN_ALL);
    endfunction

endpackage

// File: rtl/fifo_tick_gen.sv
// Free-running period timer: held at zero while disabled, pulses on the last count.
module fifo_tick_gen #(
    parameter int unsigned PERIOD = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear when disabled, wrap after the last count.
    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/fifo_rate_ctrl.sv
// Rate-controlled FIFO exerciser: timed writes/reads, traffic-mode FSM,
// sticky error flags and stretched LED activity outputs.
module fifo_rate_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned WR_PERIOD = 100_000_000,
    parameter int unsigned RD_PERIOD = 200_000_000,
    parameter int unsigned DRAIN_N   = 3,
    parameter int unsigned AF_MARGIN = 2,
    parameter int unsigned AE_MARGIN = 2,
    parameter int unsigned STRETCH   = 32'd16_777_215
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_stop,
    input  logic [1:0]                mode,
    input  logic                      clr_err,
    input  logic [DATA_W-1:0]         din,
    output logic [DATA_W-1:0]         dout,
    output logic                      wr_strobe,
    output logic                      rd_strobe,
    output logic                      wr_act,
    output logic                      rd_act,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic                      overflow,
    output logic                      underflow,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      run
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
    localparam int unsigned STR_W = $clog2(STRETCH + 1);

    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_LAST  = LVL_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] LVL_AF    = LVL_W'(DEPTH - AF_MARGIN);
    localparam logic [LVL_W-1:0] LVL_AE    = LVL_W'(AE_MARGIN);
    localparam logic [LVL_W-1:0] DRAIN_END = LVL_W'(DRAIN_N - 1);
    localparam logic [STR_W-1:0] STR_LOAD  = STR_W'(STRETCH);

    logic               ss_q;
    logic               run_q;
    logic               start_rise;
    logic               wr_tick;
    logic               rd_tick;
    state_e             state_q;
    logic [1:0]         mode_q;
    logic [LVL_W-1:0]   drain_cnt_q;
    logic [LVL_W-1:0]   level_q;
    logic [LVL_W-1:0]   level_d;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [DATA_W-1:0]  dout_q;
    logic               ovf_q;
    logic               udf_q;
    logic               ovf_d;
    logic               udf_d;
    logic [STR_W-1:0]   wr_str_q;
    logic [STR_W-1:0]   rd_str_q;
    logic [STR_W-1:0]   wr_str_d;
    logic [STR_W-1:0]   rd_str_d;
    logic               full_w;
    logic               empty_w;
    logic               wr_phase;
    logic               rd_phase;
    logic               wr_en;
    logic               rd_en;

    assign start_rise = start_stop && !ss_q;

    // Button edge detect and run toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_q  <= 1'b0;
            run_q <= 1'b0;
        end else begin
            ss_q  <= start_stop;
            run_q <= run_q ^ start_rise;
        end
    end

    fifo_tick_gen #(.PERIOD(WR_PERIOD)) u_wr_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (run_q),
        .tick (wr_tick)
    );

    fifo_tick_gen #(.PERIOD(RD_PERIOD)) u_rd_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (run_q),
        .tick (rd_tick)
    );

    // Occupancy flags and enables are taken from pre-cycle state only.
    assign full_w   = (level_q == LVL_FULL);
    assign empty_w  = (level_q == '0);
    assign wr_phase = (state_q == CONT) || (state_q == FILL);
    assign rd_phase = (state_q == CONT) || (state_q == DRAIN);
    assign wr_en    = wr_tick && wr_phase && !full_w;
    assign rd_en    = rd_tick && rd_phase && !empty_w;

    // Traffic FSM: mode latched on leaving IDLE, stop returns to IDLE from anywhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= MODE_CONT;
            drain_cnt_q <= '0;
        end else if (!run_q) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    mode_q  <= mode;
                    state_q <= is_fill_mode(mode) ? FILL : CONT;
                end
                CONT: begin
                    state_q <= CONT;
                end
                FILL: begin
                    if (wr_en && (level_q == LVL_LAST)) begin
                        state_q     <= DRAIN;
                        drain_cnt_q <= '0;
                    end
                end
                DRAIN: begin
                    if (rd_en) begin
                        drain_cnt_q <= drain_cnt_q + LVL_W'(1);
                        if ((level_q == LVL_W'(1)) ||
                            ((mode_q == MODE_DRAIN_N) && (drain_cnt_q == DRAIN_END))) begin
                            state_q <= FILL;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Level follows accepted writes and reads; simultaneous ones cancel.
    always_comb begin
        level_d = level_q;
        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointers, level and read data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            dout_q   <= '0;
        end else begin
            level_q <= level_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                dout_q   <= mem_q[rd_ptr_q];
            end
        end
    end

    // Storage array, written on the strobe edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Sticky errors: a set event in the same cycle beats clr_err.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (wr_tick && wr_phase && full_w) begin
            ovf_d = 1'b1;
        end else if (clr_err) begin
            ovf_d = 1'b0;
        end
        if (rd_tick && rd_phase && empty_w) begin
            udf_d = 1'b1;
        end else if (clr_err) begin
            udf_d = 1'b0;
        end
    end

    // Error flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    // Retriggerable LED stretch counters.
    always_comb begin
        wr_str_d = (wr_str_q != '0) ? (wr_str_q - STR_W'(1)) : '0;
        rd_str_d = (rd_str_q != '0) ? (rd_str_q - STR_W'(1)) : '0;
        if (wr_en) begin
            wr_str_d = STR_LOAD;
        end
        if (rd_en) begin
            rd_str_d = STR_LOAD;
        end
    end

    // Stretch counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_str_q <= '0;
            rd_str_q <= '0;
        end else begin
            wr_str_q <= wr_str_d;
            rd_str_q <= rd_str_d;
        end
    end

    assign dout         = dout_q;
    assign wr_strobe    = wr_en;
    assign rd_strobe    = rd_en;
    assign wr_act       = (wr_str_q != '0);
    assign rd_act       = (rd_str_q != '0);
    assign full         = full_w;
    assign empty        = empty_w;
    assign almost_full  = (level_q >= LVL_AF);
    assign almost_empty = (level_q <= LVL_AE);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
    assign level        = level_q;
    assign run          = run_q;

endmodule

// File: tb/tb_fifo_rate_ctrl.sv
// Bench for fifo_rate_ctrl: per-cycle model comparison plus directed literal checks.
module tb_fifo_rate_ctrl;

    localparam int WRP   = 4;
    localparam int RDP   = 8;
    localparam int DEP   = 8;
    localparam int DRN   = 3;
    localparam int STR   = 5;
    localparam int AFM   = 2;
    localparam int AEM   = 2;

    localparam int PH_IDLE  = 0;
    localparam int PH_CONT  = 1;
    localparam int PH_FILL  = 2;
    localparam int PH_DRAIN = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_stop;
    logic       start_stop2;
    logic [1:0] mode;
    logic       clr_err;
    logic [7:0] din;

    logic [7:0] dout, dout2;
    logic       wr_strobe, rd_strobe, wr_act, rd_act;
    logic       full, empty, almost_full, almost_empty, overflow, underflow, run;
    logic [3:0] level;
    logic       wr_strobe2, rd_strobe2, wr_act2, rd_act2;
    logic       full2, empty2, af2, ae2, overflow2, underflow2, run2;
    logic [3:0] level2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_rate_ctrl #(
        .DATA_W(8), .DEPTH(DEP), .WR_PERIOD(WRP), .RD_PERIOD(RDP), .DRAIN_N(DRN),
        .AF_MARGIN(AFM), .AE_MARGIN(AEM), .STRETCH(STR)
    ) dut (
        .clk(clk), .rst(rst), .start_stop(start_stop), .mode(mode), .clr_err(clr_err),
        .din(din), .dout(dout), .wr_strobe(wr_strobe), .rd_strobe(rd_strobe),
        .wr_act(wr_act), .rd_act(rd_act), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .overflow(overflow),
        .underflow(underflow), .level(level), .run(run)
    );

    fifo_rate_ctrl #(
        .DATA_W(8), .DEPTH(DEP), .WR_PERIOD(WRP), .RD_PERIOD(2), .DRAIN_N(DRN),
        .AF_MARGIN(AFM), .AE_MARGIN(AEM), .STRETCH(STR)
    ) dut2 (
        .clk(clk), .rst(rst), .start_stop(start_stop2), .mode(mode), .clr_err(clr_err),
        .din(din), .dout(dout2), .wr_strobe(wr_strobe2), .rd_strobe(rd_strobe2),
        .wr_act(wr_act2), .rd_act(rd_act2), .full(full2), .empty(empty2),
        .almost_full(af2), .almost_empty(ae2), .overflow(overflow2),
        .underflow(underflow2), .level(level2), .run(run2)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkv(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state for dut (spec-level view: a queue and cycle ages).
    bit         m_run, m_ss, m_ovf, m_udf, m_last_wr;
    int         m_age, m_ph, m_mode, m_dc, m_wact, m_ract;
    logic [7:0] m_dout;
    logic [7:0] mq[$];
    bit         m_wt, m_rt, m_full, m_empty, m_we, m_re;
    int         m_sz, m_nsz;

    // Model and compare, once per cycle at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            m_last_wr = wr_strobe;
            if (rst) begin
                m_run = 0; m_ss = 0; m_ovf = 0; m_udf = 0; m_age = 0;
                m_ph = PH_IDLE; m_mode = 0; m_dc = 0; m_wact = 0; m_ract = 0;
                m_dout = 8'h00; mq.delete();
            end
            m_sz    = mq.size();
            m_full  = (m_sz == DEP);
            m_empty = (m_sz == 0);
            m_wt    = m_run && ((m_age % WRP) == WRP - 1);
            m_rt    = m_run && ((m_age % RDP) == RDP - 1);
            m_we    = m_wt && !m_full && (m_ph == PH_CONT || m_ph == PH_FILL);
            m_re    = m_rt && !m_empty && (m_ph == PH_CONT || m_ph == PH_DRAIN);

            chk1("m_wr_strobe", wr_strobe, m_we);
            chk1("m_rd_strobe", rd_strobe, m_re);
            chk1("m_full", full, m_full);
            chk1("m_empty", empty, m_empty);
            chk1("m_almost_full", almost_full, m_sz >= DEP - AFM);
            chk1("m_almost_empty", almost_empty, m_sz <= AEM);
            chkv("m_level", int'(level), m_sz);
            chkv("m_dout", int'(dout), int'(m_dout));
            chk1("m_overflow", overflow, m_ovf);
            chk1("m_underflow", underflow, m_udf);
            chk1("m_run", run, m_run);
            chk1("m_wr_act", wr_act, m_wact != 0);
            chk1("m_rd_act", rd_act, m_ract != 0);

            if (!rst) begin
                if (m_wt && m_full && (m_ph == PH_CONT || m_ph == PH_FILL)) m_ovf = 1;
                else if (clr_err) m_ovf = 0;
                if (m_rt && m_empty && (m_ph == PH_CONT || m_ph == PH_DRAIN)) m_udf = 1;
                else if (clr_err) m_udf = 0;
                if (m_re) m_dout = mq.pop_front();
                if (m_we) mq.push_back(din);
                m_nsz = mq.size();
                if (!m_run) begin
                    m_ph = PH_IDLE;
                end else if (m_ph == PH_IDLE) begin
                    m_mode = int'(mode);
                    m_ph   = (mode == 2'd1 || mode == 2'd2) ? PH_FILL : PH_CONT;
                end else if (m_ph == PH_FILL) begin
                    if (m_we && m_nsz == DEP) begin
                        m_ph = PH_DRAIN;
                        m_dc = 0;
                    end
                end else if (m_ph == PH_DRAIN && m_re) begin
                    m_dc++;
                    if (m_nsz == 0 || (m_mode == 1 && m_dc == DRN)) m_ph = PH_FILL;
                end
                m_wact = m_we ? STR : (m_wact > 0 ? m_wact - 1 : 0);
                m_ract = m_re ? STR : (m_ract > 0 ? m_ract - 1 : 0);
                m_age  = m_run ? m_age + 1 : 0;
                m_run  = m_run ^ (start_stop && !m_ss);
                m_ss   = start_stop;
            end
        end
    end

    bit auto_din;

    // One clock; din advances after every accepted write when auto_din is set.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (auto_din && m_last_wr) din = din + 8'd1;
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1;
        cyc();
        start_stop = 1'b0;
        cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic wait_full(input string name);
        int n = 0;
        while (!full && n < 200) begin
            cyc();
            n++;
        end
        chk1(name, full, 1'b1);
    endtask

    task automatic wait_reads(input string name, input int cnt);
        int n = 0;
        int k = 0;
        while (k < cnt && n < 200) begin
            if (rd_strobe) k++;
            cyc();
            n++;
        end
        chkv(name, k, cnt);
    endtask

    task automatic wait_write(input string name);
        int n = 0;
        while (!wr_strobe && n < 40) begin
            cyc();
            n++;
        end
        chk1(name, wr_strobe, 1'b1);
    endtask

    initial begin
        automatic logic exp_rd[6] = '{0, 0, 0, 0, 0, 1};
        automatic logic exp_wr[6] = '{0, 0, 0, 1, 0, 0};
        automatic logic exp_uf[6] = '{0, 0, 1, 1, 1, 1};
        automatic int   exp_lv[6] = '{0, 0, 0, 0, 1, 1};
        int n;

        rst = 1'b1; start_stop = 1'b0; start_stop2 = 1'b0; mode = 2'd0;
        clr_err = 1'b0; din = 8'h00; auto_din = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        chk1("init_empty", empty, 1'b1);
        chkv("init_level", int'(level), 0);

        // Fill/drain-N: 8 writes, 3 reads down to level 5, then filling again.
        mode = 2'd1; din = 8'h00; auto_din = 1'b1;
        pulse_ss();
        chk1("t2_run", run, 1'b1);
        wait_full("t2_full");
        chkv("t2_level_full", int'(level), 8);
        wait_reads("t2_reads", 3);
        chkv("t2_level5", int'(level), 5);
        chkv("t2_dout", int'(dout), 2);
        chk1("t2_no_ovf", overflow, 1'b0);
        wait_write("t2_refill");

        // Reset during traffic.
        rst = 1'b1;
        #1;
        chk1("t1_empty", empty, 1'b1);
        chk1("t1_ae", almost_empty, 1'b1);
        chkv("t1_level", int'(level), 0);
        chkv("t1_dout", int'(dout), 0);
        chk1("t1_run", run, 1'b0);
        chk1("t1_full", full, 1'b0);
        chk1("t1_wr_act", wr_act, 1'b0);
        chk1("t1_ovf", overflow, 1'b0);
        cyc();
        rst = 1'b0;
        cyc();

        // Fill/drain-all: data 0x10..0x17 comes back in order, then FILL.
        mode = 2'd2; din = 8'h10;
        pulse_ss();
        wait_full("t3_full");
        for (int i = 0; i < 8; i++) begin
            n = 0;
            while (!rd_strobe && n < 40) begin
                cyc();
                n++;
            end
            chk1("t3_rd_seen", rd_strobe, 1'b1);
            cyc();
            chkv("t3_dout", int'(dout), 16 + i);
        end
        chk1("t3_empty", empty, 1'b1);
        wait_write("t3_refill");
        do_reset();

        // Continuous: level climbs to full, overflow, then cleared after stopping.
        mode = 2'd0;
        pulse_ss();
        n = 0;
        while (!overflow && n < 400) begin
            cyc();
            n++;
        end
        chk1("t4_ovf_set", overflow, 1'b1);
        pulse_ss();
        chk1("t4_stopped", run, 1'b0);
        chk1("t4_ovf_sticky", overflow, 1'b1);
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        chk1("t4_ovf_clr", overflow, 1'b0);
        chk1("t4_udf", underflow, 1'b0);
        do_reset();

        // Stop in DRAIN at level 6, restart in CONT.
        mode = 2'd2;
        pulse_ss();
        wait_full("t6_full");
        wait_reads("t6_reads", 2);
        chkv("t6_level6", int'(level), 6);
        pulse_ss();
        for (int i = 0; i < 20; i++) begin
            chk1("t6_idle_wr", wr_strobe, 1'b0);
            chk1("t6_idle_rd", rd_strobe, 1'b0);
            chkv("t6_hold", int'(level), 6);
            cyc();
        end
        mode = 2'd0;
        pulse_ss();
        wait_write("t6_cont_wr");
        cyc();
        chkv("t6_level7", int'(level), 7);
        for (int i = 0; i < 4; i++) begin
            chk1("t6_wr_act", wr_act, 1'b1);
            cyc();
        end

        // RD_PERIOD=2 instance: read tick on empty FIFO sets underflow, no strobe.
        start_stop2 = 1'b1;
        cyc();
        start_stop2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk1("t5_rd_strobe", rd_strobe2, exp_rd[i]);
            chk1("t5_wr_strobe", wr_strobe2, exp_wr[i]);
            chk1("t5_underflow", underflow2, exp_uf[i]);
            chkv("t5_level", int'(level2), exp_lv[i]);
            cyc();
        end
        chk1("t5_overflow", overflow2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
